// File: rtl/gate_response_checker.sv
// Response checker for 2-input gate tests: compares out1 against the latched gate function,
// counts vectors/mismatches, tracks input coverage. Optional macro: GATE_CHECK_FIRST_FAIL_EN.
module gate_response_checker #(
  parameter int CNT_W          = 8,
  parameter int EXPECT_VECTORS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       gate_sel,
  input  logic             sample_valid,
  input  logic             in1,
  input  logic             in2,
  input  logic             out1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov
`ifdef GATE_CHECK_FIRST_FAIL_EN
  ,
  output logic [2:0]       first_fail,
  output logic             first_fail_valid
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPECT_VECTORS);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic             pass_q, pass_d;
  logic             expected_s;
  logic             run_sample_s;
  logic             mismatch_s;

  // Expected gate output for the latched function.
  always_comb begin
    expected_s = 1'b0;
    case (sel_q)
      2'b00:   expected_s = in1 & in2;
      2'b01:   expected_s = in1 | in2;
      2'b10:   expected_s = in1 ^ in2;
      2'b11:   expected_s = ~(in1 & in2);
      default: expected_s = 1'b0;
    endcase
  end

  // start has priority, so a sample arriving with start is dropped.
  assign run_sample_s = ~start & (state_q == ST_RUN) & sample_valid;
  assign mismatch_s   = run_sample_s & (out1 != expected_s);

  // Next-state, counter and coverage logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    vec_cnt_d = vec_cnt_q;
    err_cnt_d = err_cnt_q;
    cov_d     = cov_q;
    if (start) begin
      state_d   = ST_RUN;
      sel_d     = gate_sel;
      vec_cnt_d = CNT_ZERO;
      err_cnt_d = CNT_ZERO;
      cov_d     = 4'h0;
    end else if (run_sample_s) begin
      vec_cnt_d              = vec_cnt_q + CNT_ONE;
      cov_d[{in1, in2}]      = 1'b1;
      if (mismatch_s && (err_cnt_q != CNT_SAT)) begin
        err_cnt_d = err_cnt_q + CNT_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (vec_cnt_d == CNT_LAST) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = state_q;
    end
    pass_d = (state_d == ST_DONE) && (err_cnt_d == CNT_ZERO) && (cov_d == 4'hF);
  end

  // Main state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'b00;
      vec_cnt_q <= CNT_ZERO;
      err_cnt_q <= CNT_ZERO;
      cov_q     <= 4'h0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      vec_cnt_q <= vec_cnt_d;
      err_cnt_q <= err_cnt_d;
      cov_q     <= cov_d;
      pass_q    <= pass_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign pass    = pass_q;
  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;
  assign cov     = cov_q;

`ifdef GATE_CHECK_FIRST_FAIL_EN
  logic [2:0] first_fail_q, first_fail_d;
  logic       first_fail_valid_q, first_fail_valid_d;

  // Capture only the first mismatch of a run.
  always_comb begin
    first_fail_d       = first_fail_q;
    first_fail_valid_d = first_fail_valid_q;
    if (start) begin
      first_fail_d       = 3'b000;
      first_fail_valid_d = 1'b0;
    end else if (mismatch_s && !first_fail_valid_q) begin
      first_fail_d       = {in1, in2, out1};
      first_fail_valid_d = 1'b1;
    end else begin
      first_fail_d       = first_fail_q;
      first_fail_valid_d = first_fail_valid_q;
    end
  end

  // First-fail capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_fail_q       <= 3'b000;
      first_fail_valid_q <= 1'b0;
    end else begin
      first_fail_q       <= first_fail_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign first_fail       = first_fail_q;
  assign first_fail_valid = first_fail_valid_q;
`endif

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: directed table, hand-written corner
// sequences, and randomized traffic against a behavioural model.
module tb_gate_response_checker;

  localparam int CNT_W = 8;
  localparam int EXP_V = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       gate_sel;
  logic             sample_valid;
  logic             in1, in2, out1;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_cnt, err_cnt;
  logic [3:0]       cov;
`ifdef GATE_CHECK_FIRST_FAIL_EN
  logic [2:0]       first_fail;
  logic             first_fail_valid;
`endif

  gate_response_checker #(.CNT_W(CNT_W), .EXPECT_VECTORS(EXP_V)) dut (
    .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
    .sample_valid(sample_valid), .in1(in1), .in2(in2), .out1(out1),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov(cov)
`ifdef GATE_CHECK_FIRST_FAIL_EN
    , .first_fail(first_fail), .first_fail_valid(first_fail_valid)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit       m_run, m_done;
  int       m_sel, m_vec, m_err, m_ff;
  bit [3:0] m_cov;
  bit       m_ffv;

  function automatic int gate_fn(int sel, int a, int b);
    case (sel)
      0:       return a * b;
      1:       return (a + b > 0) ? 1 : 0;
      2:       return (a + b) % 2;
      default: return 1 - a * b;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_sel = 0; m_vec = 0; m_err = 0;
    m_cov = 4'h0; m_ffv = 0; m_ff = 0;
  endtask

  task automatic model_step(bit st, int sel, bit v, int a, int b, int o);
    if (st) begin
      m_run = 1; m_done = 0; m_sel = sel; m_vec = 0; m_err = 0;
      m_cov = 4'h0; m_ffv = 0; m_ff = 0;
    end else if (m_run && v) begin
      m_vec++;
      m_cov[a * 2 + b] = 1'b1;
      if (o != gate_fn(m_sel, a, b)) begin
        if (m_err < (1 << CNT_W) - 1) m_err++;
        if (!m_ffv) begin
          m_ffv = 1;
          m_ff  = a * 4 + b * 2 + o;
        end
      end
      if (m_vec == EXP_V) begin
        m_run  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".pass"}, int'(pass), (m_done && m_err == 0 && m_cov == 4'hF) ? 1 : 0);
    chk({tag, ".vec_cnt"}, int'(vec_cnt), m_vec);
    chk({tag, ".err_cnt"}, int'(err_cnt), m_err);
    chk({tag, ".cov"}, int'(cov), int'(m_cov));
`ifdef GATE_CHECK_FIRST_FAIL_EN
    chk({tag, ".ffv"}, int'(first_fail_valid), int'(m_ffv));
    chk({tag, ".ff"}, int'(first_fail), m_ff);
`endif
  endtask

  // Drive one cycle, step the model, compare everything.
  task automatic cyc(string tag, bit st, logic [1:0] sel, bit v, bit a, bit b, bit o);
    start = st; gate_sel = sel; sample_valid = v; in1 = a; in2 = b; out1 = o;
    @(posedge clk); #1;
    model_step(st, int'(sel), v, int'(a), int'(b), int'(o));
    check_all(tag);
  endtask

  typedef struct {
    bit       st;
    bit [1:0] sel;
    bit       v, a, b, o;
    bit       e_done;
    int       e_vec;
    int       e_err;
    bit [3:0] e_cov;
    bit       e_pass;
    bit       e_ffv;
    bit [2:0] e_ff;
  } vec_t;

  function automatic vec_t mk(bit st, bit [1:0] sel, bit v, bit a, bit b, bit o,
                              bit ed, int ev, int ee, bit [3:0] ec, bit ep,
                              bit effv, bit [2:0] eff);
    vec_t r;
    r.st = st; r.sel = sel; r.v = v; r.a = a; r.b = b; r.o = o;
    r.e_done = ed; r.e_vec = ev; r.e_err = ee; r.e_cov = ec; r.e_pass = ep;
    r.e_ffv = effv; r.e_ff = eff;
    return r;
  endfunction

  vec_t tbl[15];

  initial begin
    // clean AND run
    tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 3'b000);
    tbl[1]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 3'b000);
    tbl[2]  = mk(0, 2'b00, 1, 1, 0, 0, 0, 2, 0, 4'b0101, 0, 0, 3'b000);
    tbl[3]  = mk(0, 2'b00, 1, 0, 1, 0, 0, 3, 0, 4'b0111, 0, 0, 3'b000);
    tbl[4]  = mk(0, 2'b00, 1, 1, 1, 1, 1, 4, 0, 4'b1111, 1, 0, 3'b000);
    // single mismatch on the last vector
    tbl[5]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 3'b000);
    tbl[6]  = mk(0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 3'b000);
    tbl[7]  = mk(0, 2'b00, 1, 1, 0, 0, 0, 2, 0, 4'b0101, 0, 0, 3'b000);
    tbl[8]  = mk(0, 2'b00, 1, 0, 1, 0, 0, 3, 0, 4'b0111, 0, 0, 3'b000);
    tbl[9]  = mk(0, 2'b00, 1, 1, 1, 0, 1, 4, 1, 4'b1111, 0, 1, 3'b110);
    // coverage hole
    tbl[10] = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 3'b000);
    tbl[11] = mk(0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 3'b000);
    tbl[12] = mk(0, 2'b00, 1, 0, 0, 0, 0, 2, 0, 4'b0001, 0, 0, 3'b000);
    tbl[13] = mk(0, 2'b00, 1, 0, 1, 0, 0, 3, 0, 4'b0011, 0, 0, 3'b000);
    tbl[14] = mk(0, 2'b00, 1, 1, 1, 1, 1, 4, 0, 4'b1011, 0, 0, 3'b000);

    rst = 1'b1; start = 1'b0; gate_sel = 2'b00; sample_valid = 1'b0;
    in1 = 1'b0; in2 = 1'b0; out1 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // samples in IDLE are ignored
    cyc("idle0", 0, 2'b00, 1, 1, 1, 0);
    cyc("idle1", 0, 2'b01, 1, 0, 1, 0);
    chk("idle.vec_cnt", int'(vec_cnt), 0);

    for (int i = 0; i < 15; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sel, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].o);
      chk($sformatf("tbl%0d.done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d.vec", i), int'(vec_cnt), tbl[i].e_vec);
      chk($sformatf("tbl%0d.err", i), int'(err_cnt), tbl[i].e_err);
      chk($sformatf("tbl%0d.cov", i), int'(cov), int'(tbl[i].e_cov));
      chk($sformatf("tbl%0d.pass", i), int'(pass), int'(tbl[i].e_pass));
`ifdef GATE_CHECK_FIRST_FAIL_EN
      chk($sformatf("tbl%0d.ffv", i), int'(first_fail_valid), int'(tbl[i].e_ffv));
      chk($sformatf("tbl%0d.ff", i), int'(first_fail), int'(tbl[i].e_ff));
`endif
    end

    // samples in DONE are ignored
    cyc("done_ign", 0, 2'b00, 1, 1, 0, 1);
    chk("done_ign.vec", int'(vec_cnt), 4);

    // XOR with gaps; gate_sel changed to AND mid-run has no effect
    cyc("xor_s", 1, 2'b10, 0, 0, 0, 0);
    cyc("xor1", 0, 2'b10, 1, 0, 0, 0);
    cyc("xor_g1", 0, 2'b00, 0, 1, 1, 1);
    cyc("xor2", 0, 2'b00, 1, 0, 1, 1);
    cyc("xor_g2", 0, 2'b00, 0, 0, 0, 1);
    cyc("xor_g3", 0, 2'b00, 0, 1, 0, 0);
    cyc("xor3", 0, 2'b00, 1, 1, 0, 1);
    chk("xor3.done", int'(done), 0);
    cyc("xor4", 0, 2'b00, 1, 1, 1, 0);
    chk("xor4.done", int'(done), 1);
    chk("xor4.pass", int'(pass), 1);

    // restart after 2 vectors; sample with start is discarded
    cyc("rs_s", 1, 2'b01, 0, 0, 0, 0);
    cyc("rs1", 0, 2'b01, 1, 0, 0, 0);
    cyc("rs2", 0, 2'b01, 1, 1, 1, 1);
    cyc("rs_re", 1, 2'b01, 1, 1, 0, 1);
    chk("rs_re.vec", int'(vec_cnt), 0);
    cyc("rs3", 0, 2'b01, 1, 0, 0, 0);
    cyc("rs4", 0, 2'b01, 1, 0, 1, 1);
    cyc("rs5", 0, 2'b01, 1, 1, 0, 1);
    chk("rs5.done", int'(done), 0);
    cyc("rs6", 0, 2'b01, 1, 1, 1, 1);
    chk("rs6.done", int'(done), 1);

    // asynchronous reset mid-run
    cyc("ar_s", 1, 2'b11, 0, 0, 0, 0);
    cyc("ar1", 0, 2'b11, 1, 0, 0, 0);
    cyc("ar2", 0, 2'b11, 1, 1, 1, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.busy", int'(busy), 0);
    chk("arst.vec", int'(vec_cnt), 0);
    chk("arst.err", int'(err_cnt), 0);
    check_all("arst");
    #2 rst = 1'b0;
    cyc("post_rst0", 0, 2'b11, 1, 0, 0, 1);
    cyc("post_rst1", 0, 2'b11, 1, 1, 1, 0);
    chk("post_rst.vec", int'(vec_cnt), 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit st, v, a, b, o;
      logic [1:0] sel;
      st  = ($urandom_range(0, 11) == 0);
      sel = 2'($urandom_range(0, 3));
      v   = ($urandom_range(0, 3) != 0);
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      o   = 1'(gate_fn(m_sel, int'(a), int'(b)));
      if ($urandom_range(0, 7) == 0) o = ~o;
      cyc("rand", st, sel, v, a, b, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable response checker for 2-input gate tests: the receiving end of the `in1`/`in2` stimulus applied to gate blocks such as `and_gate`. Each cycle it takes one applied vector plus the gate's `out1` and compares `out1` with the expected function. It counts vectors and mismatches and tracks coverage of the four input combinations. After a fixed number of vectors it reports pass/fail, so gate benches and on-board self-tests need no hand-written checks.

## Interface
Parameters:
- `CNT_W`, 8: width of vector and error counters.
- `EXPECT_VECTORS`, 4: vectors per run. Range 1..2^CNT_W-1.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: begin or restart a run.
- `gate_sel`  in  2: expected function, captured on `start`. 00 AND, 01 OR, 10 XOR, 11 NAND.
- `sample_valid`  in  1: `in1`/`in2`/`out1` hold a vector this cycle.
- `in1`, `in2`  in  1 each: stimulus applied to the gate under test.
- `out1`  in  1: gate response.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete. Held until the next `start` or `rst`.
- `pass`  out  1: `done` && `err_cnt`==0 && `cov`==4'hF.
- `vec_cnt`  out  CNT_W: vectors checked.
- `err_cnt`  out  CNT_W: mismatches, saturating.
- `cov`  out  4: bit {in1,in2} is set once that combination has been checked.
- `first_fail`  out  3: {in1,in2,out1} of the first mismatch. Present only with `GATE_CHECK_FIRST_FAIL_EN`.
- `first_fail_valid`  out  1: `first_fail` is meaningful. Present only with `GATE_CHECK_FIRST_FAIL_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last vector--> DONE.
  - DONE --start--> RUN.
  - RUN --start--> RUN (restart).
- On `start`:
  - Latch `gate_sel`.
  - Clear `vec_cnt`, `err_cnt`, `cov`, `first_fail_valid`.
  - `start` wins over `sample_valid` in the same cycle; that sample is discarded.
- In RUN, on a cycle with `sample_valid` high:
  - Compute the expected value from the latched function: AND in1&in2, OR in1|in2, XOR in1^in2, NAND ~(in1&in2).
  - `vec_cnt`++.
  - `cov[{in1,in2}]` <= 1.
  - If `out1` != expected, `err_cnt`++, holding at all-ones once saturated.
- The sample that brings `vec_cnt` to `EXPECT_VECTORS` moves the FSM to DONE on the same edge.
- `sample_valid` in IDLE or DONE is ignored: no counter or coverage change.
- Gaps in `sample_valid` are allowed; the run length counts valid samples only.
- `busy` = (state==RUN). `done` = (state==DONE). `pass` is derived from registered state.

## Timing
- All outputs are registered. A sample at edge N is reflected in the outputs after edge N.
- `start` at edge N gives `busy`=1, `done`=0, and cleared counters after edge N.
- Run latency: with one valid sample per cycle, `done` is set after the edge that captures sample `EXPECT_VECTORS`.
- `rst` asserted (asynchronous):
  - FSM goes to IDLE immediately.
  - All outputs are 0: `busy`, `done`, `pass`, `vec_cnt`, `err_cnt`, `cov`, `first_fail`, `first_fail_valid`.
  - The latched function resets to AND.
- `rst` mid-run aborts the run with no result. A fresh `start` is required after reset.

## Configuration
- Macro: `GATE_CHECK_FIRST_FAIL_EN`.
- Defined:
  - `first_fail` and `first_fail_valid` exist.
  - The first mismatch of a run captures {in1,in2,out1} and sets `first_fail_valid`.
  - Later mismatches do not overwrite the capture.
  - `start` and `rst` clear both outputs.
- Undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- **Clean AND run:** reset, `gate_sel`=00, `start`, then vectors (in1,in2,out1) = 000, 100, 010, 111, back-to-back. Required: `done`=1 the cycle after the 4th, `vec_cnt`=4, `err_cnt`=0, `cov`=4'hF, `pass`=1.
- **Single mismatch:** same run, but the last vector is 110. Required: `err_cnt`=1, `pass`=0. With the macro defined, `first_fail`=3'b110 and `first_fail_valid`=1.
- **Coverage hole:** AND, vectors 000, 000, 010, 111, all correct. Required: `cov`=4'b1011, `err_cnt`=0, `pass`=0.
- **Stalls and ignored samples:**
  - Apply valid samples in IDLE: no change, `vec_cnt`=0.
  - Run XOR (`gate_sel`=10) with `sample_valid` gaps, vectors 000, 011, 101, 110. Required: `done` only after the 4th valid sample, `pass`=1.
  - Change `gate_sel` mid-run to 00: no effect.
- **Restart and reset:**
  - `start` after 2 of 4 vectors: counters clear, 4 more vectors are needed.
  - Assert `rst` mid-run between clock edges: all outputs 0 immediately, before the next edge.
  - Samples after reset without `start` are ignored.
